gpio_input_conditioner: RTL and testbench

//  Per-channel synchronizer and debouncer for raw board buttons and switches.

---
 rtl/gpio_input_conditioner.sv | 167 ++++++++++++++++
 tb/tb_gpio_input_conditioner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input_conditioner
// Purpose  : Per-channel two-flop synchronizer and debouncer for raw board
//            buttons and switches. Produces clean levels, one-cycle rise/fall
//            pulses and an event/irq indication for the interrupt path.
// Macro    : GPIO_COND_STICKY_EN - when defined, evt_status holds each event
//            until it is cleared by writing one to evt_clr. A set and a clear
//            in the same cycle leave the flag set. When undefined,
//            evt_status is rise|fall and evt_clr is ignored.
// Ports    : clk        - system clock
//            rst        - synchronous, active-high reset
//            raw_in     - asynchronous raw pad inputs        [N_IN]
//            clean_out  - debounced level per channel         [N_IN]
//            rise       - 1-cycle pulse on a clean 0->1 change [N_IN]
//            fall       - 1-cycle pulse on a clean 1->0 change [N_IN]
//            evt_clr    - write-one-to-clear for sticky flags  [N_IN]
//            evt_status - per-channel event flags              [N_IN]
//            irq        - OR-reduction of evt_status
// Revision : 1.0 - initial release
// ============================================================================
module gpio_input_conditioner #(
  parameter int              N_IN      = 4,
  parameter int              DB_CYCLES = 20000,
  parameter logic [N_IN-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_IN-1:0] raw_in,
  output logic [N_IN-1:0] clean_out,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] fall,
  input  logic [N_IN-1:0] evt_clr,
  output logic [N_IN-1:0] evt_status,
  output logic            irq
);

  localparam int               CNT_W      = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Two-flop synchronizer; r_sync2 is the sampled level seen by the debouncer.
  // --------------------------------------------------------------------------
  logic [N_IN-1:0] r_sync1;
  logic [N_IN-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
    end else begin
      r_sync1 <= raw_in;
      r_sync2 <= r_sync1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel debounce FSM. A channel accepts a new level only after it has
  // differed from the clean level for DB_CYCLES consecutive cycles; any return
  // to the clean level before that discards the count.
  // --------------------------------------------------------------------------
  logic [N_IN-1:0] w_rise;
  logic [N_IN-1:0] w_fall;

  for (genvar i = 0; i < N_IN; i++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;
    logic             r_rise;
    logic             r_fall;
    logic             w_diff;
    logic             w_last;

    assign w_diff = r_sync2[i] ^ r_clean;
    // In STABLE the counter is always zero, so this also covers DB_CYCLES=1,
    // where the first differing sample is accepted immediately.
    assign w_last = (r_cnt == C_CNT_LAST);

    always_ff @(posedge clk) begin
      if (rst) begin
        r_state <= ST_STABLE;
        r_cnt   <= '0;
        r_clean <= RESET_VAL[i];
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        case (r_state)
          ST_STABLE: begin
            r_cnt <= '0;
            if (w_diff) begin
              if (w_last) begin
                r_clean <= r_sync2[i];
                r_rise  <= r_sync2[i];
                r_fall  <= ~r_sync2[i];
              end else begin
                r_cnt   <= C_CNT_ONE;
                r_state <= ST_COUNT;
              end
            end
          end
          ST_COUNT: begin
            if (!w_diff) begin
              // Glitch: level came back before acceptance.
              r_cnt   <= '0;
              r_state <= ST_STABLE;
            end else if (w_last) begin
              r_clean <= r_sync2[i];
              r_rise  <= r_sync2[i];
              r_fall  <= ~r_sync2[i];
              r_cnt   <= '0;
              r_state <= ST_STABLE;
            end else begin
              r_cnt <= r_cnt + C_CNT_ONE;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_STABLE;
          end
        endcase
      end
    end

    assign clean_out[i] = r_clean;
    assign w_rise[i]    = r_rise;
    assign w_fall[i]    = r_fall;
  end

  assign rise = w_rise;
  assign fall = w_fall;

  // --------------------------------------------------------------------------
  // Event reporting
  // --------------------------------------------------------------------------
`ifdef GPIO_COND_STICKY_EN
  logic [N_IN-1:0] r_evt;

  // Flags are set from the registered pulses, so a clear issued while a pulse
  // is visible loses to that pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt <= '0;
    end else begin
      r_evt <= (r_evt & ~evt_clr) | w_rise | w_fall;
    end
  end

  assign evt_status = r_evt;
  assign irq        = |r_evt;
`else
  logic w_unused_evt_clr;

  assign w_unused_evt_clr = ^evt_clr;
  assign evt_status       = w_rise | w_fall;
  assign irq              = |(w_rise | w_fall);
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_input_conditioner
// Purpose  : Directed self-checking bench for gpio_input_conditioner with
//            DB_CYCLES=4 and RESET_VAL=0 (accept latency 6 edges).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input_conditioner;

  localparam int N_IN = 4;

  logic            clk;
  logic            rst;
  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] clean_out;
  logic [N_IN-1:0] rise;
  logic [N_IN-1:0] fall;
  logic [N_IN-1:0] evt_clr;
  logic [N_IN-1:0] evt_status;
  logic            irq;

  int checks;
  int errors;

  gpio_input_conditioner #(
    .N_IN      (N_IN),
    .DB_CYCLES (4),
    .RESET_VAL (4'b0000)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .raw_in     (raw_in),
    .clean_out  (clean_out),
    .rise       (rise),
    .fall       (fall),
    .evt_clr    (evt_clr),
    .evt_status (evt_status),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_flags();
    evt_clr = 4'hF;
    step();
    evt_clr = 4'h0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    raw_in  = 4'hF;
    evt_clr = 4'h0;

    // 1. Reset held 3 cycles with pads high, then accept after 6 edges.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_clean", clean_out, 4'h0);
      chk("rst_rise", rise, 4'h0);
      chk("rst_irq", irq, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("rel_clean_wait", clean_out, 4'h0);
    end
    step();
    chk("rel_clean", clean_out, 4'hF);
    chk("rel_rise", rise, 4'hF);
    chk("rel_fall", fall, 4'h0);
`ifndef GPIO_COND_STICKY_EN
    chk("rel_evt", evt_status, 4'hF);
    chk("rel_irq", irq, 1'b1);
`endif
    step();
    chk("rel_rise_end", rise, 4'h0);
`ifdef GPIO_COND_STICKY_EN
    chk("rel_evt_sticky", evt_status, 4'hF);
    chk("rel_irq_sticky", irq, 1'b1);
    clear_flags();
`endif
    chk("rel_evt_idle", evt_status, 4'h0);
    chk("rel_irq_idle", irq, 1'b0);

    // Return all channels low.
    raw_in = 4'h0;
    for (int k = 1; k <= 5; k++) step();
    step();
    chk("low_clean", clean_out, 4'h0);
    chk("low_fall", fall, 4'hF);
    chk("low_rise", rise, 4'h0);
    step();
    chk("low_fall_end", fall, 4'h0);
    clear_flags();

    // 2. Three-cycle glitch on ch0 is rejected.
    raw_in = 4'h1;
    for (int k = 0; k < 13; k++) begin
      if (k == 3) raw_in = 4'h0;
      step();
      chk("glitch_clean", clean_out, 4'h0);
      chk("glitch_pulse", rise | fall, 4'h0);
    end

    // 3. Bounce on ch1: 1,0,1 then held; accept 6 edges after last 0->1.
    raw_in = 4'h2;
    step();
    raw_in = 4'h0;
    step();
    raw_in = 4'h2;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("bounce_clean_wait", clean_out, 4'h0);
      chk("bounce_rise_wait", rise, 4'h0);
    end
    step();
    chk("bounce_clean", clean_out, 4'h2);
    chk("bounce_rise", rise, 4'h2);
    step();
    chk("bounce_rise_end", rise, 4'h0);

    // 4. ch2 and ch3 change together.
    raw_in = 4'hE;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("simul_rise_wait", rise, 4'h0);
    end
    step();
    chk("simul_rise", rise, 4'hC);
    chk("simul_clean", clean_out, 4'hE);
    step();
    chk("simul_rise_end", rise, 4'h0);
    clear_flags();
    chk("evt_cleared", evt_status, 4'h0);

    // 5. Event flags on ch0.
`ifdef GPIO_COND_STICKY_EN
    raw_in = 4'hF;
    for (int k = 1; k <= 6; k++) step();
    chk("st_rise0", rise, 4'h1);
    step();
    chk("st_evt_set", evt_status, 4'h1);
    chk("st_irq_set", irq, 1'b1);
    raw_in = 4'hE;
    for (int k = 1; k <= 6; k++) step();
    chk("st_fall0", fall, 4'h1);
    evt_clr = 4'h1;
    step();
    chk("st_set_wins", evt_status, 4'h1);
    chk("st_irq_held", irq, 1'b1);
    step();
    chk("st_evt_clr", evt_status, 4'h0);
    chk("st_irq_clr", irq, 1'b0);
    evt_clr = 4'h0;
`else
    raw_in = 4'hF;
    for (int k = 1; k <= 6; k++) step();
    chk("ns_evt_rise", evt_status, 4'h1);
    chk("ns_irq_rise", irq, 1'b1);
    step();
    chk("ns_evt_end", evt_status, 4'h0);
    chk("ns_irq_end", irq, 1'b0);
    raw_in  = 4'hE;
    evt_clr = 4'hF;
    for (int k = 1; k <= 6; k++) step();
    chk("ns_evt_fall", evt_status, 4'h1);
    chk("ns_irq_fall", irq, 1'b1);
    step();
    evt_clr = 4'h0;
    chk("ns_evt_end2", evt_status, 4'h0);
    chk("ns_irq_end2", irq, 1'b0);
`endif

    // 6. Reset after two counting cycles on ch3.
    raw_in = 4'h6;
    for (int k = 1; k <= 4; k++) step();
    chk("mid_clean_pre", clean_out, 4'hE);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("mid_rst_clean", clean_out, 4'h0);
      chk("mid_rst_pulse", rise | fall, 4'h0);
      chk("mid_rst_evt", evt_status, 4'h0);
      chk("mid_rst_irq", irq, 1'b0);
    end
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("post_clean_wait", clean_out, 4'h0);
      chk("post_rise_wait", rise, 4'h0);
    end
    step();
    chk("post_clean", clean_out, 4'h6);
    chk("post_rise", rise, 4'h6);
    chk("post_fall", fall, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
